regfile_scoreboard: RTL and testbench

Parametrised integer register file for the RISC-V core with N asynchronous read ports, two write-back ports and a per-register busy scoreboard. Sits between decode (read/issue) and the two write-back sources: the single-cycle ALU path (port A) and the long-latency load/multiply path (port B). Provides write-through bypass so decode sees same-cycle write-back data and pending-write status without extra forwarding logic.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_bypass_mux.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the integer register file and its read-port muxes.
package regfile_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = 32;
  localparam int ZERO_IDX    = 0;
  localparam int SP_IDX_DEF  = 2;
  localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;
  localparam int DBG_IDX_DEF = 17;

  // Address width for a register file of n entries (at least one bit).
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: forwards same-cycle write-back data and hides busy on a same-cycle clear.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] arr_word,
  input  logic            busy_bit,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic valid;
  logic wa_hit;
  logic wb_hit;

  // x0 and out-of-range addresses never forward and never report busy.
  assign valid  = (addr != AW'(ZERO_IDX)) && ({1'b0, addr} < NREGS_W);
  assign wa_hit = valid && wa_en && (wa_addr == addr);
  assign wb_hit = valid && wb_en && (wb_addr == addr);

  // Port A is the younger producer, so it takes priority over port B.
  always_comb begin
    data = arr_word;
    if (!valid)      data = '0;
    else if (wa_hit) data = wa_data;
    else if (wb_hit) data = wb_data;
  end

  assign busy = valid && busy_bit && !wb_hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two write-back ports, N bypassed read ports and a busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int              XLEN    = XLEN_DEF,
  parameter int              NREGS   = NREGS_DEF,
  parameter int              NREAD   = 2,
  parameter int              SP_IDX  = SP_IDX_DEF,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
  parameter int              DBG_IDX = DBG_IDX_DEF,
  localparam int             AW      = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wa_en,
  input  logic [AW-1:0]         wa_addr,
  input  logic [XLEN-1:0]       wa_data,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic [XLEN-1:0]       dbg_reg,
  output logic                  waw_err
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wa_ok, wb_ok, iss_ok, waw_hit;

  // Writable target: non-zero and inside the file.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != AW'(ZERO_IDX)) && ({1'b0, a} < NREGS_W);
  endfunction

  assign wa_ok  = wa_en  && addr_ok(wa_addr);
  assign wb_ok  = wb_en  && addr_ok(wb_addr);
  assign iss_ok = iss_en && addr_ok(iss_addr);

  // A second issue to a still-pending register is a WAW hazard unless port B retires it now.
  assign waw_hit = iss_ok && busy[iss_addr] && !(wb_ok && (wb_addr == iss_addr));

  // Clear on port-B write-back, then set on issue so a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_ok)  busy_nxt[wb_addr]  = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[ZERO_IDX] = 1'b0;
  end

  // Array, scoreboard and sticky error; port A is written last so it wins a shared target.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= (r == SP_IDX) ? SP_INIT : '0;
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      if (wb_ok) regs[wb_addr] <= wb_data;
      if (wa_ok) regs[wa_addr] <= wa_data;
      busy <= busy_nxt;
      if (waw_hit) waw_err <= 1'b1;
    end
  end

  assign dbg_reg = regs[DBG_IDX];

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic            in_rng;
    logic [XLEN-1:0] word;
    logic            bz;

    assign a      = rd_addr[p*AW +: AW];
    assign in_rng = ({1'b0, a} < NREGS_W);
    assign word   = in_rng ? regs[a] : '0;
    assign bz     = in_rng ? busy[a] : 1'b0;

    regfile_bypass_mux #(
      .XLEN  (XLEN),
      .AW    (AW),
      .NREGS (NREGS)
    ) u_mux (
      .addr     (a),
      .arr_word (word),
      .busy_bit (bz),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .data     (rd_data[p*XLEN +: XLEN]),
      .busy     (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a behavioural model checked every cycle.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
  localparam int SPI   = 2;
  localparam int DBGI  = 17;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wa_en, wb_en, iss_en;
  logic [AW-1:0]         wa_addr, wb_addr, iss_addr;
  logic [XLEN-1:0]       wa_data, wb_data;
  logic [XLEN-1:0]       dbg_reg;
  logic                  waw_err;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD),
    .SP_IDX(SPI), .SP_INIT(32'h2ffc), .DBG_IDX(DBGI)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .dbg_reg(dbg_reg), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk     = 1'b0;

  // Architectural state of the model.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_waw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wa_en && wa_addr == a) return wa_data;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic logic [XLEN-1:0] rdp(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    iss_en = 0; iss_addr = 0;
  endtask

  // Wait for the falling edge and compare every output against the model.
  task automatic at_neg();
    @(negedge clk);
    if (chk) begin
      for (int p = 0; p < NREAD; p++) begin
        check($sformatf("rd_data[%0d]", p), rdp(p), exp_rd(rd_addr[p*AW +: AW]));
        check($sformatf("rd_busy[%0d]", p), rd_busy[p], exp_busy(rd_addr[p*AW +: AW]));
      end
      check("dbg_reg", dbg_reg, m_regs[DBGI]);
      check("waw_err", waw_err, m_waw);
    end
  endtask

  // Advance past the rising edge, applying the architectural effect of this cycle's inputs.
  task automatic adv();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = (r == SPI) ? 32'h2ffc : '0;
        m_busy[r] = 1'b0;
      end
      m_waw = 1'b0;
    end else begin
      if (iss_en && iss_addr != 0 && m_busy[iss_addr] && !(wb_en && wb_addr == iss_addr))
        m_waw = 1'b1;
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (wa_en && wa_addr != 0) m_regs[wa_addr] = wa_data;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; idle(); rd_addr = '0;
    adv(); adv();
    reset = 1'b0; chk = 1'b1;

    // Reset state
    set_rd(0, 2); set_rd(1, 0);
    at_neg();
    check("reset_sp", rdp(0), 32'h2ffc);
    check("reset_x0", rdp(1), 32'h0);
    check("reset_busy", rd_busy, 2'b00);
    check("reset_dbg", dbg_reg, 32'h0);
    check("reset_waw", waw_err, 1'b0);
    adv();

    // Port A bypass then array
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEAD_BEEF; set_rd(0, 5);
    at_neg(); check("wa_bypass", rdp(0), 32'hDEAD_BEEF);
    adv(); idle();
    at_neg(); check("wa_array", rdp(0), 32'hDEAD_BEEF);
    adv();

    // Both ports to 17: A wins
    wa_en = 1; wa_addr = 17; wa_data = 32'h1;
    wb_en = 1; wb_addr = 17; wb_data = 32'h2; set_rd(0, 17);
    at_neg(); check("ab_prio_bypass", rdp(0), 32'h1);
    adv(); idle();
    at_neg(); check("ab_prio_dbg", dbg_reg, 32'h1); check("ab_prio_array", rdp(0), 32'h1);
    adv();

    // Port B only, read on port 1 while port 0 reads an array value
    wb_en = 1; wb_addr = 20; wb_data = 32'hABC; set_rd(0, 5); set_rd(1, 20);
    at_neg(); check("wb_bypass_p1", rdp(1), 32'hABC); check("p0_array", rdp(0), 32'hDEAD_BEEF);
    adv(); idle();

    // Issue / clear on reg 9
    iss_en = 1; iss_addr = 9; set_rd(1, 9);
    at_neg(); check("iss_not_same_cycle", rd_busy[1], 1'b0);
    adv(); idle();
    at_neg(); check("iss_busy", rd_busy[1], 1'b1);
    adv();
    wb_en = 1; wb_addr = 9; wb_data = 32'h55;
    at_neg(); check("clr_busy_bypass", rd_busy[1], 1'b0); check("clr_data", rdp(1), 32'h55);
    adv(); idle();
    at_neg(); check("clr_busy_held", rd_busy[1], 1'b0);
    adv();
    iss_en = 1; iss_addr = 9;
    at_neg(); adv();
    wb_en = 1; wb_addr = 9; wb_data = 32'h66; iss_en = 1; iss_addr = 9;
    at_neg(); check("set_clr_same_bypass", rd_busy[1], 1'b0);
    adv(); idle();
    at_neg();
    check("set_wins", rd_busy[1], 1'b1);
    check("no_waw_on_clear", waw_err, 1'b0);
    check("set_clr_data", rdp(1), 32'h66);
    adv();

    // WAW: reissue while busy
    iss_en = 1; iss_addr = 9;
    at_neg(); adv(); idle();
    at_neg(); check("waw_set", waw_err, 1'b1);
    adv();
    at_neg(); check("waw_held", waw_err, 1'b1);
    adv();

    // Register 0 ignores everything
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF;
    wb_en = 1; wb_addr = 0; wb_data = 32'hEEEE;
    iss_en = 1; iss_addr = 0; set_rd(0, 0); set_rd(1, 0);
    at_neg(); check("x0_bypass", rdp(0), 32'h0); check("x0_busy", rd_busy, 2'b00);
    adv(); idle();
    at_neg(); check("x0_array", rdp(1), 32'h0); check("x0_busy_next", rd_busy, 2'b00);
    adv();

    // Reset dominates pending busy, a write and an issue
    reset = 1; wa_en = 1; wa_addr = 3; wa_data = 32'h33; iss_en = 1; iss_addr = 9;
    at_neg(); adv();
    reset = 0; idle(); set_rd(0, 3); set_rd(1, 9);
    at_neg();
    check("rst_reg3", rdp(0), 32'h0);
    check("rst_busy9", rd_busy[1], 1'b0);
    check("rst_waw", waw_err, 1'b0);
    adv();
    set_rd(0, 2); set_rd(1, 5);
    at_neg(); check("rst_sp", rdp(0), 32'h2ffc); check("rst_reg5", rdp(1), 32'h0);
    adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
